// File: rtl/cordic_job_sched.sv
// cordic_job_sched: round-robin scheduler sharing one CORDIC core
// between NREQ requesters, with core reset sequencing and timeout.
module cordic_job_sched #(
  parameter int NREQ    = 2,
  parameter int RST_CYC = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*10-1:0]   req_data,
  input  logic [NREQ-1:0]      req_mode,
  input  logic [NREQ-1:0]      req_osel,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [10:0]          rsp_data,
  output logic                 rsp_err,
  output logic [11:0]          core_in,
  output logic                 core_rst_n,
  input  logic                 core_ready,
  input  logic [11:0]          core_out,
  output logic                 busy
);

  localparam int GW = $clog2(NREQ);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_RDY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] to_cnt;

  logic          pick;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] arb_idx;
  logic [9:0]    data_a [NREQ];
  logic          done;
  logic          expired;
  logic          rsp_hs;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_a[i] = req_data[10*i +: 10];
    end
  end

  // Scan from lowest to highest priority so the nearest
  // requester after last_grant overwrites the others.
  always_comb begin
    pick     = 1'b0;
    pick_idx = '0;
    arb_idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      arb_idx = GW'((int'(last_grant) + k) % NREQ);
      if (req_valid[arb_idx]) begin
        pick     = 1'b1;
        pick_idx = arb_idx;
      end
    end
  end

  assign done    = core_out[11];
  assign expired = (to_cnt == TW'(TIMEOUT - 1));
  assign rsp_hs  = rsp_ready[last_grant];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GW'(NREQ - 1);
      rst_cnt    <= '0;
      to_cnt     <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      core_in    <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
    end else begin
      req_ready <= '0;
      unique case (state)
        IDLE: begin
          if (pick) begin
            req_ready[pick_idx] <= 1'b1;
            core_in    <= {req_osel[pick_idx],
                           req_mode[pick_idx],
                           data_a[pick_idx]};
            last_grant <= pick_idx;
            rst_cnt    <= '0;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (rst_cnt == RW'(RST_CYC - 1)) begin
            core_rst_n <= 1'b1;
            to_cnt     <= '0;
            state      <= WAIT_RDY;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        WAIT_RDY: begin
          to_cnt <= to_cnt + 1'b1;
          if (expired) begin
            rsp_data              <= '0;
            rsp_err               <= 1'b1;
            rsp_valid[last_grant] <= 1'b1;
            core_rst_n            <= 1'b0;
            state                 <= RESP;
          end else if (core_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          to_cnt <= to_cnt + 1'b1;
          if (done) begin
            rsp_data              <= core_out[10:0];
            rsp_err               <= 1'b0;
            rsp_valid[last_grant] <= 1'b1;
            core_rst_n            <= 1'b0;
            state                 <= RESP;
          end else if (expired) begin
            rsp_data              <= '0;
            rsp_err               <= 1'b1;
            rsp_valid[last_grant] <= 1'b1;
            core_rst_n            <= 1'b0;
            state                 <= RESP;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
